// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wreq_t;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned QDEPTH_DEF       = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/rf_wq_fifo.sv
// In-order shift queue for MDU results: head at entry 0, squashed entries are
// removed and the survivors compact toward the head.
module rf_wq_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  wreq_t                  i_push_req,
  input  logic                   i_pop,
  input  logic [QDEPTH-1:0]      i_squash,
  output logic [QDEPTH-1:0]      o_valid,
  output logic [QDEPTH-1:0][4:0] o_addr,
  output wreq_t                  o_head,
  output logic [2:0]             o_count
);

  wreq_t [QDEPTH-1:0] r_entry;
  wreq_t [QDEPTH-1:0] w_entry_d;
  logic  [QDEPTH-1:0] r_valid;
  logic  [QDEPTH-1:0] w_valid_d;
  logic  [2:0]        r_count;
  logic  [2:0]        w_count_d;
  logic  [2:0]        w_wr_idx;

  always_comb begin
    w_entry_d = r_entry;
    w_valid_d = '0;
    w_wr_idx  = '0;
    // Survivors are copied down in order; w_wr_idx tracks the next free slot.
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_valid[i] && !i_squash[i] && !((i == 0) && i_pop)) begin
        for (int j = 0; j < QDEPTH; j++) begin
          if (w_wr_idx == 3'(j)) begin
            w_entry_d[j] = r_entry[i];
            w_valid_d[j] = 1'b1;
          end
        end
        w_wr_idx = w_wr_idx + 3'd1;
      end
    end
    if (i_push) begin
      for (int j = 0; j < QDEPTH; j++) begin
        if (w_wr_idx == 3'(j)) begin
          w_entry_d[j] = i_push_req;
          w_valid_d[j] = 1'b1;
        end
      end
    end
    w_count_d = w_wr_idx + {2'b00, i_push};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry <= '0;
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_entry <= w_entry_d;
      r_valid <= w_valid_d;
      r_count <= w_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      o_addr[i] = r_entry[i].addr;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_entry[0];
  assign o_count = r_count;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, MDU results are
// bypassed when possible or queued in order, with hazard flags and a starvation stall.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH       = QDEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        wa_clk,
  input  logic        wa_rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        stall_req,
  output logic [2:0]  q_count
);

  logic                   w_pipe_req;
  logic                   w_mdu_live;
  logic                   w_mdu_waw;
  logic                   w_q_nonempty;
  logic                   w_pop;
  logic                   w_bypass;
  logic                   w_push;
  wreq_t                  w_push_req;
  wreq_t                  w_q_head;
  logic [QDEPTH-1:0]      w_q_valid;
  logic [QDEPTH-1:0][4:0] w_q_addr;
  logic [QDEPTH-1:0]      w_squash;
  logic [2:0]             w_q_count;
  logic                   w_hit1;
  logic                   w_hit2;
  logic [3:0]             r_age;
  logic [3:0]             w_age_d;
  logic                   r_stall;

  assign w_pipe_req   = pipe_we && (pipe_waddr != REG_ZERO);
  assign mdu_ready    = (w_q_count < 3'(QDEPTH));
  // An accepted offer that still needs a register-file write.
  assign w_mdu_live   = mdu_valid && mdu_ready && (mdu_waddr != REG_ZERO);
  assign w_mdu_waw    = w_pipe_req && (mdu_waddr == pipe_waddr);
  assign w_q_nonempty = w_q_valid[0];
  assign w_pop        = !w_pipe_req && w_q_nonempty;
  assign w_bypass     = !w_pipe_req && !w_q_nonempty && w_mdu_live;
  assign w_push       = w_mdu_live && !w_bypass && !w_mdu_waw;
  assign w_push_req   = {mdu_waddr, mdu_wdata};

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      w_squash[i] = w_pipe_req && w_q_valid[i] && (w_q_addr[i] == pipe_waddr);
    end
  end

  rf_wq_fifo #(
    .QDEPTH(QDEPTH)
  ) u_wq_fifo (
    .i_clk      (wa_clk),
    .i_rst_n    (wa_rst_n),
    .i_push     (w_push),
    .i_push_req (w_push_req),
    .i_pop      (w_pop),
    .i_squash   (w_squash),
    .o_valid    (w_q_valid),
    .o_addr     (w_q_addr),
    .o_head     (w_q_head),
    .o_count    (w_q_count)
  );

  // Reset gates the write port immediately, independent of any clock edge.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (wa_rst_n) begin
      if (w_pipe_req) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end else if (w_pop) begin
        rf_we    = 1'b1;
        rf_waddr = w_q_head.addr;
        rf_wdata = w_q_head.data;
      end else if (w_bypass) begin
        rf_we    = 1'b1;
        rf_waddr = mdu_waddr;
        rf_wdata = mdu_wdata;
      end
    end
  end

  always_comb begin
    w_hit1 = w_mdu_live && (mdu_waddr == rd_addr1);
    w_hit2 = w_mdu_live && (mdu_waddr == rd_addr2);
    for (int i = 0; i < QDEPTH; i++) begin
      w_hit1 = w_hit1 || (w_q_valid[i] && (w_q_addr[i] == rd_addr1));
      w_hit2 = w_hit2 || (w_q_valid[i] && (w_q_addr[i] == rd_addr2));
    end
  end

  assign pend_hit1 = wa_rst_n && w_hit1 && (rd_addr1 != REG_ZERO);
  assign pend_hit2 = wa_rst_n && w_hit2 && (rd_addr2 != REG_ZERO);

  always_comb begin
    w_age_d = r_age;
    if (w_pop || w_squash[0]) begin
      w_age_d = '0;
    end else if (w_q_nonempty && (r_age != 4'(STARVE_LIMIT))) begin
      w_age_d = r_age + 4'd1;
    end
  end

  always_ff @(posedge wa_clk or negedge wa_rst_n) begin
    if (!wa_rst_n) begin
      r_age   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_age   <= w_age_d;
      r_stall <= (w_age_d == 4'(STARVE_LIMIT));
    end
  end

  assign stall_req = r_stall;
  assign q_count   = w_q_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected MDU writes are queued as offers
// are accepted and retired against register-file writes at each falling edge.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic        wa_clk = 1'b0;
  logic        wa_rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_waddr = '0;
  logic [31:0] mdu_wdata = '0;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        stall_req;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_pass   = 0;
  wreq_t exp_q[$];

  always #5 wa_clk = ~wa_clk;

  rf_wb_arbiter dut (
    .wa_clk     (wa_clk),
    .wa_rst_n   (wa_rst_n),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .mdu_valid  (mdu_valid),
    .mdu_waddr  (mdu_waddr),
    .mdu_wdata  (mdu_wdata),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .pend_hit1  (pend_hit1),
    .pend_hit2  (pend_hit2),
    .stall_req  (stall_req),
    .q_count    (q_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(posedge wa_clk);
    #1;
    pipe_we    = pwe;
    pipe_waddr = pa;
    pipe_wdata = pd;
    mdu_valid  = mv;
    mdu_waddr  = ma;
    mdu_wdata  = md;
  endtask

  // Write-port monitor: pipe writes are immediate, otherwise the oldest
  // expected MDU result must be written, otherwise the port stays idle.
  always @(negedge wa_clk) begin
    wreq_t w;
    if (!wa_rst_n) begin
      check_eq("rst_we", rf_we, 0);
    end else if (pipe_we && pipe_waddr != 5'd0) begin
      check_eq("pipe_we", rf_we, 1);
      check_eq("pipe_addr", rf_waddr, pipe_waddr);
      check_eq("pipe_data", rf_wdata, pipe_wdata);
    end else if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      check_eq("mdu_we", rf_we, 1);
      check_eq("mdu_addr", rf_waddr, w.addr);
      check_eq("mdu_data", rf_wdata, w.data);
    end else begin
      check_eq("idle_we", rf_we, 0);
    end
  end

  initial begin
    repeat (3) @(posedge wa_clk);
    #1 wa_rst_n = 1'b1;
    @(negedge wa_clk);
    check_eq("rst_ready", mdu_ready, 1);
    check_eq("rst_qcnt", q_count, 0);
    check_eq("rst_stall", stall_req, 0);
    check_eq("rst_hit1", pend_hit1, 0);

    // Bypass: empty queue, no pipe write.
    drive(0, 5'd0, 32'h0, 1, 5'd5, 32'h1234);
    exp_q.push_back('{addr: 5'd5, data: 32'h1234});
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("byp_qcnt", q_count, 0);

    // Starvation: pipe owns the port while two results queue up.
    drive(1, 5'd3, 32'h3000_0001, 1, 5'd7, 32'hAA);
    exp_q.push_back('{addr: 5'd7, data: 32'hAA});
    drive(1, 5'd3, 32'h3000_0002, 1, 5'd8, 32'hBB);
    exp_q.push_back('{addr: 5'd8, data: 32'hBB});
    @(negedge wa_clk);
    check_eq("stv_qcnt1", q_count, 1);
    check_eq("stv_ready1", mdu_ready, 1);
    drive(1, 5'd3, 32'h3000_0003, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("stv_qcnt2", q_count, 2);
    check_eq("stv_full_ready", mdu_ready, 0);
    check_eq("stv_stall_early", stall_req, 0);
    drive(1, 5'd3, 32'h3000_0004, 0, 5'd0, 32'h0);
    drive(1, 5'd3, 32'h3000_0005, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("stv_stall_3", stall_req, 0);
    rd_addr1 = 5'd8;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("stv_stall_4", stall_req, 1);
    check_eq("stv_qcnt_hold", q_count, 2);
    check_eq("stv_hit_x8", pend_hit1, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("stv_stall_drop", stall_req, 0);
    check_eq("stv_qcnt_pop", q_count, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("stv_qcnt_empty", q_count, 0);
    check_eq("stv_ready_back", mdu_ready, 1);

    // WAW squash of a queued entry.
    rd_addr2 = 5'd9;
    drive(1, 5'd4, 32'h44, 1, 5'd9, 32'h99);
    exp_q.push_back('{addr: 5'd9, data: 32'h99});
    @(negedge wa_clk);
    check_eq("sq_hit_offer", pend_hit2, 1);
    rd_addr1 = 5'd9;
    drive(1, 5'd9, 32'h55, 0, 5'd0, 32'h0);
    void'(exp_q.pop_back()); // younger pipe write supersedes the queued x9
    @(negedge wa_clk);
    check_eq("sq_qcnt_before", q_count, 1);
    check_eq("sq_hit_before", pend_hit1, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("sq_qcnt_after", q_count, 0);
    check_eq("sq_hit_after", pend_hit1, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Same-cycle WAW: offer to the register the pipe is writing is dropped.
    drive(1, 5'd6, 32'h66, 1, 5'd6, 32'h60);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("waw_qcnt", q_count, 0);

    // x0 writes on both paths.
    rd_addr1 = 5'd0;
    drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD);
    @(negedge wa_clk);
    check_eq("x0_ready", mdu_ready, 1);
    check_eq("x0_hit", pend_hit1, 0);
    drive(1, 5'd0, 32'hBEEF, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("x0_qcnt", q_count, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Asynchronous reset with two results queued.
    rd_addr1 = 5'd10;
    drive(1, 5'd3, 32'h3000_0010, 1, 5'd10, 32'hA0);
    exp_q.push_back('{addr: 5'd10, data: 32'hA0});
    drive(1, 5'd3, 32'h3000_0011, 1, 5'd11, 32'hB0);
    exp_q.push_back('{addr: 5'd11, data: 32'hB0});
    drive(1, 5'd3, 32'h3000_0012, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("rq_qcnt", q_count, 2);
    check_eq("rq_hit", pend_hit1, 1);
    #2;
    wa_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("ar_qcnt", q_count, 0);
    check_eq("ar_ready", mdu_ready, 1);
    check_eq("ar_we", rf_we, 0);
    check_eq("ar_waddr", rf_waddr, 0);
    check_eq("ar_wdata", rf_wdata, 0);
    check_eq("ar_stall", stall_req, 0);
    check_eq("ar_hit1", pend_hit1, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(posedge wa_clk);
    #1 wa_rst_n = 1'b1;
    @(negedge wa_clk);
    check_eq("ar_qcnt_rel", q_count, 0);
    check_eq("ar_hit_rel", pend_hit1, 0);

    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(negedge wa_clk);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
